// File: rtl/yl3_dec_formatter_if.sv
// Value/handshake bundle between the value source, yl3_dec_formatter and the YL-3 driver.
// hex_mode exists only when YL3_FMT_HEX_EN is defined.
interface yl3_dec_formatter_if #(
   parameter int unsigned Width = 27
) ();
   logic [Width-1:0] value;
   logic             value_valid;
`ifdef YL3_FMT_HEX_EN
   logic             hex_mode;
`endif
   logic             busy;
   logic [63:0]      data;
   logic             load;
   logic             ready;
   logic             ovf;

`ifdef YL3_FMT_HEX_EN
   modport master (output value, value_valid, hex_mode, ready,
                   input  busy, data, load, ovf);
   modport slave  (input  value, value_valid, hex_mode, ready,
                   output busy, data, load, ovf);
`else
   modport master (output value, value_valid, ready,
                   input  busy, data, load, ovf);
   modport slave  (input  value, value_valid, ready,
                   output busy, data, load, ovf);
`endif
endinterface

// File: rtl/yl3_dec_formatter.sv
// Binary to 8-char right-justified ASCII formatter (serial double-dabble) feeding the YL-3 driver.
// Optional hexadecimal mode is enabled by defining YL3_FMT_HEX_EN.
module yl3_dec_formatter #(
   parameter int unsigned Width   = 27,
   parameter bit          BlankLz = 1'b1
) (
   input logic                 clk_i,
   input logic                 rst_i,
   yl3_dec_formatter_if.slave  bus_io
);
   typedef enum logic [1:0] {StIdle, StConvert, StFormat, StSend} state_e;

   localparam logic [63:0] BlankStr = {8{8'h20}};
   localparam logic [63:0] ErrStr   = 64'h4572_7220_2020_2020;

   state_e      state_q, state_d;
   logic [31:0] value_q, value_d;
   logic [31:0] bcd_q, bcd_d;
   logic [4:0]  cnt_q, cnt_d;  // 5 bits so Width up to 32 fits
   logic [63:0] data_q, data_d;
   logic        ovf_q, ovf_d;
   logic        seen_rdy_q, seen_rdy_d;
   logic        is_hex;
   logic        start_hex;

`ifdef YL3_FMT_HEX_EN
   logic hex_q, hex_d;
   assign is_hex    = hex_q;
   assign start_hex = bus_io.hex_mode;
`else
   assign is_hex    = 1'b0;
   assign start_hex = 1'b0;
`endif

   logic [31:0] bcd_adj;
   logic [4:0]  bit_idx;
   logic [31:0] nib_src;
   logic [63:0] fmt_data;
   logic        fmt_ovf;
   logic        lead;
   logic [3:0]  nib;

   function automatic logic [7:0] glyph(input logic [3:0] n);
      case (n)
         4'hA:    glyph = 8'h41;
         4'hB:    glyph = 8'h62;
         4'hC:    glyph = 8'h43;
         4'hD:    glyph = 8'h64;
         4'hE:    glyph = 8'h45;
         4'hF:    glyph = 8'h46;
         default: glyph = 8'h30 + {4'h0, n};
      endcase
   endfunction

   assign bit_idx = 5'(Width - 1) - cnt_q;

   always_comb begin
      bcd_adj = '0;
      for (int i = 0; i < 8; i++) begin
         bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                        : bcd_q[4*i +: 4];
      end
   end

   // Leading-zero run is tracked left to right; the rightmost character is never blanked.
   always_comb begin
      nib_src  = is_hex ? value_q : bcd_q;
      fmt_data = '0;
      fmt_ovf  = 1'b0;
      lead     = BlankLz;
      nib      = '0;
      for (int i = 7; i >= 0; i--) begin
         nib = nib_src[4*i +: 4];
         if (lead && (nib == 4'd0) && (i != 0)) begin
            fmt_data[8*i +: 8] = 8'h20;
         end else begin
            fmt_data[8*i +: 8] = glyph(nib);
            lead               = 1'b0;
         end
      end
      if (!is_hex && (value_q > 32'd99_999_999)) begin
         fmt_ovf  = 1'b1;
         fmt_data = ErrStr;
      end
   end

   always_comb begin
      state_d    = state_q;
      value_d    = value_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      data_d     = data_q;
      ovf_d      = ovf_q;
      seen_rdy_d = seen_rdy_q;
`ifdef YL3_FMT_HEX_EN
      hex_d      = hex_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (bus_io.value_valid) begin
               value_d    = 32'(bus_io.value);
               bcd_d      = '0;
               cnt_d      = '0;
               ovf_d      = 1'b0;
               seen_rdy_d = 1'b0;
`ifdef YL3_FMT_HEX_EN
               hex_d      = start_hex;
`endif
               state_d    = start_hex ? StFormat : StConvert;
            end
         end
         StConvert: begin
            bcd_d = {bcd_adj[30:0], value_q[bit_idx]};
            if (cnt_q == 5'(Width - 1)) begin
               state_d = StFormat;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         StFormat: begin
            data_d  = fmt_data;
            ovf_d   = fmt_ovf;
            state_d = StSend;
         end
         StSend: begin
            // The driver signals acceptance by dropping READY after having raised it.
            if (bus_io.ready) begin
               seen_rdy_d = 1'b1;
            end else if (seen_rdy_q) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         value_q    <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         data_q     <= BlankStr;
         ovf_q      <= 1'b0;
         seen_rdy_q <= 1'b0;
`ifdef YL3_FMT_HEX_EN
         hex_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         value_q    <= value_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         data_q     <= data_d;
         ovf_q      <= ovf_d;
         seen_rdy_q <= seen_rdy_d;
`ifdef YL3_FMT_HEX_EN
         hex_q      <= hex_d;
`endif
      end
   end

   assign bus_io.busy = (state_q != StIdle);
   assign bus_io.load = (state_q == StSend);
   assign bus_io.data = data_q;
   assign bus_io.ovf  = ovf_q;

endmodule
